// File: rtl/usb_cdc_stream_bridge.sv
// Byte-stream bridge between the usb_cdc OUT/IN ports and the application byte interface.
// Holds independent RX and TX FIFOs, an internal loopback path, and a drop counter for unconfigured periods.
module usb_cdc_stream_bridge #(
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int DROP_UNCONF = 1,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        configured_i,
    input  logic                        loopback_i,
    input  logic [7:0]                  usb_out_data_i,
    input  logic                        usb_out_valid_i,
    output logic                        usb_out_ready_o,
    output logic [7:0]                  usb_in_data_o,
    output logic                        usb_in_valid_o,
    input  logic                        usb_in_ready_i,
    output logic [7:0]                  app_rx_data_o,
    output logic                        app_rx_valid_o,
    input  logic                        app_rx_ready_i,
    input  logic [7:0]                  app_tx_data_i,
    input  logic                        app_tx_valid_i,
    output logic                        app_tx_ready_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o,
    input  logic                        drop_clr_i
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_LW = RX_AW + 1;
    localparam int TX_LW = TX_AW + 1;
    localparam logic [RX_LW-1:0] RX_FULL_LVL = RX_LW'(RX_DEPTH);
    localparam logic [TX_LW-1:0] TX_FULL_LVL = TX_LW'(TX_DEPTH);
    localparam logic DROP_EN = (DROP_UNCONF != 0);

    // alive_reg keeps every handshake closed until the first edge after reset release
    logic alive_reg;
    logic lp_reg;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_reg, rx_wr_ptr_next;
    logic [RX_AW-1:0] rx_rd_ptr_reg, rx_rd_ptr_next;
    logic [RX_LW-1:0] rx_level_reg,  rx_level_next;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_reg, tx_wr_ptr_next;
    logic [TX_AW-1:0] tx_rd_ptr_reg, tx_rd_ptr_next;
    logic [TX_LW-1:0] tx_level_reg,  tx_level_next;

    logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic       run;
    logic       rx_full, rx_empty, tx_full, tx_empty;
    logic       rx_rd_valid, tx_rd_valid, tx_wr_ready;
    logic       rx_push, rx_pop, tx_push, tx_pop;
    logic       echo, app_tx_hs, drop_inc;
    logic [7:0] rx_head, tx_head, tx_wr_data;

    assign run      = alive_reg & configured_i;
    assign rx_full  = (rx_level_reg == RX_FULL_LVL);
    assign rx_empty = (rx_level_reg == '0);
    assign tx_full  = (tx_level_reg == TX_FULL_LVL);
    assign tx_empty = (tx_level_reg == '0);
    assign rx_head  = rx_mem[rx_rd_ptr_reg];
    assign tx_head  = tx_mem[tx_rd_ptr_reg];

    assign rx_rd_valid = run & ~rx_empty;
    assign tx_rd_valid = run & ~tx_empty;
    assign tx_wr_ready = run & ~tx_full;

    assign usb_out_ready_o = run & ~rx_full;
    assign usb_in_valid_o  = tx_rd_valid;
    assign app_rx_valid_o  = rx_rd_valid & ~lp_reg;

    always_comb begin
        app_tx_ready_o = 1'b0;
        if (!lp_reg) begin
            if (configured_i) app_tx_ready_o = tx_wr_ready;
            else              app_tx_ready_o = alive_reg & DROP_EN;
        end
    end

    // In loopback the RX head is moved straight into the TX FIFO
    assign echo       = lp_reg & rx_rd_valid & tx_wr_ready;
    assign app_tx_hs  = app_tx_valid_i & app_tx_ready_o;
    assign rx_push    = usb_out_valid_i & usb_out_ready_o;
    assign rx_pop     = lp_reg ? echo : (app_rx_valid_o & app_rx_ready_i);
    assign tx_push    = lp_reg ? echo : (app_tx_hs & configured_i);
    assign tx_pop     = tx_rd_valid & usb_in_ready_i;
    assign tx_wr_data = lp_reg ? rx_head : app_tx_data_i;
    assign drop_inc   = app_tx_hs & ~configured_i;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data_mask
            assign app_rx_data_o[gi] = app_rx_valid_o & rx_head[gi];
            assign usb_in_data_o[gi] = usb_in_valid_o & tx_head[gi];
        end
    endgenerate

    always_comb begin
        rx_wr_ptr_next = rx_wr_ptr_reg;
        rx_rd_ptr_next = rx_rd_ptr_reg;
        rx_level_next  = rx_level_reg;
        if (!configured_i) begin
            rx_wr_ptr_next = '0;
            rx_rd_ptr_next = '0;
            rx_level_next  = '0;
        end else begin
            if (rx_push) rx_wr_ptr_next = rx_wr_ptr_reg + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr_next = rx_rd_ptr_reg + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level_next = rx_level_reg + RX_LW'(1);
                2'b01:   rx_level_next = rx_level_reg - RX_LW'(1);
                default: rx_level_next = rx_level_reg;
            endcase
        end
    end

    always_comb begin
        tx_wr_ptr_next = tx_wr_ptr_reg;
        tx_rd_ptr_next = tx_rd_ptr_reg;
        tx_level_next  = tx_level_reg;
        if (!configured_i) begin
            tx_wr_ptr_next = '0;
            tx_rd_ptr_next = '0;
            tx_level_next  = '0;
        end else begin
            if (tx_push) tx_wr_ptr_next = tx_wr_ptr_reg + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr_next = tx_rd_ptr_reg + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level_next = tx_level_reg + TX_LW'(1);
                2'b01:   tx_level_next = tx_level_reg - TX_LW'(1);
                default: tx_level_next = tx_level_reg;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop_clr_i)
            drop_cnt_next = '0;
        else if (drop_inc && (drop_cnt_reg != '1))
            drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            alive_reg     <= 1'b0;
            lp_reg        <= 1'b0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_level_reg  <= '0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_level_reg  <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            alive_reg     <= 1'b1;
            lp_reg        <= loopback_i;
            rx_wr_ptr_reg <= rx_wr_ptr_next;
            rx_rd_ptr_reg <= rx_rd_ptr_next;
            rx_level_reg  <= rx_level_next;
            tx_wr_ptr_reg <= tx_wr_ptr_next;
            tx_rd_ptr_reg <= tx_rd_ptr_next;
            tx_level_reg  <= tx_level_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= usb_out_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= tx_wr_data;
    end

    assign rx_level_o = rx_level_reg;
    assign tx_level_o = tx_level_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_usb_cdc_stream_bridge.sv
// Scoreboard bench for usb_cdc_stream_bridge: drivers feed byte queues, a negedge monitor
// tracks expected FIFO contents as plain queues and checks every output handshake.
module tb_usb_cdc_stream_bridge;
    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam int DW  = 4;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_i, configured_i, loopback_i, drop_clr_i;
    logic [7:0] usb_out_data_i, app_tx_data_i;
    logic       usb_out_valid_i, usb_in_ready_i, app_rx_ready_i, app_tx_valid_i;
    logic       usb_out_ready_o, usb_in_valid_o, app_rx_valid_o, app_tx_ready_o;
    logic [7:0] usb_in_data_o, app_rx_data_o;
    logic [$clog2(RXD):0] rx_level_o;
    logic [$clog2(TXD):0] tx_level_o;
    logic [DW-1:0]        drop_cnt_o;

    usb_cdc_stream_bridge #(
        .RX_DEPTH(RXD), .TX_DEPTH(TXD), .DROP_UNCONF(1), .DROP_CNT_W(DW)
    ) u_dut (
        .clk_i(clk), .rstn_i(rstn_i), .configured_i(configured_i), .loopback_i(loopback_i),
        .usb_out_data_i(usb_out_data_i), .usb_out_valid_i(usb_out_valid_i), .usb_out_ready_o(usb_out_ready_o),
        .usb_in_data_o(usb_in_data_o), .usb_in_valid_o(usb_in_valid_o), .usb_in_ready_i(usb_in_ready_i),
        .app_rx_data_o(app_rx_data_o), .app_rx_valid_o(app_rx_valid_o), .app_rx_ready_i(app_rx_ready_i),
        .app_tx_data_i(app_tx_data_i), .app_tx_valid_i(app_tx_valid_i), .app_tx_ready_o(app_tx_ready_o),
        .rx_level_o(rx_level_o), .tx_level_o(tx_level_o),
        .drop_cnt_o(drop_cnt_o), .drop_clr_i(drop_clr_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    logic [7:0] host_src[$];
    logic [7:0] app_src[$];
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int  drop_m = 0;
    bit  lp_prev = 1'b0;
    bit  alive_prev = 1'b0;
    int  rx_rdy_mode = 0;
    int  tx_rdy_mode = 0;
    bit  host_burst = 1'b1;
    bit  app_burst = 1'b1;

    // Scoreboard: outputs pop expected bytes before this cycle's inputs are queued
    always @(negedge clk) begin : monitor
        bit lp_eff;
        bit alive;
        if (!rstn_i) begin
            rxq.delete();
            txq.delete();
            drop_m     = 0;
            lp_prev    = 1'b0;
            alive_prev = 1'b0;
        end else begin
            lp_eff = lp_prev;
            alive  = alive_prev;
            chk("drop_cnt", int'(drop_cnt_o), drop_m);
            if (lp_eff) begin
                chk("lp_levels", int'(rx_level_o) + int'(tx_level_o), txq.size());
            end else begin
                chk("rx_level", int'(rx_level_o), rxq.size());
                chk("tx_level", int'(tx_level_o), txq.size());
            end
            if (!alive || !configured_i) begin
                chk("out_ready_idle", usb_out_ready_o, 0);
                chk("in_valid_idle", usb_in_valid_o, 0);
                chk("rx_valid_idle", app_rx_valid_o, 0);
                chk("tx_ready_idle", app_tx_ready_o, (alive && !lp_eff) ? 1 : 0);
            end else if (lp_eff) begin
                chk("lp_rx_valid", app_rx_valid_o, 0);
                chk("lp_tx_ready", app_tx_ready_o, 0);
            end else begin
                chk("out_ready", usb_out_ready_o, rxq.size() < RXD);
                chk("rx_valid", app_rx_valid_o, rxq.size() > 0);
                chk("in_valid", usb_in_valid_o, txq.size() > 0);
                chk("tx_ready", app_tx_ready_o, txq.size() < TXD);
            end
            if (app_rx_valid_o && app_rx_ready_i) begin
                if (rxq.size() == 0) chk("rx_underflow", 1, 0);
                else chk("rx_data", app_rx_data_o, rxq.pop_front());
            end
            if (usb_in_valid_o && usb_in_ready_i) begin
                if (txq.size() == 0) chk("tx_underflow", 1, 0);
                else chk("in_data", usb_in_data_o, txq.pop_front());
            end
            if (usb_out_valid_i && usb_out_ready_o) begin
                if (lp_eff) txq.push_back(usb_out_data_i);
                else        rxq.push_back(usb_out_data_i);
            end
            if (app_tx_valid_i && app_tx_ready_o && configured_i) txq.push_back(app_tx_data_i);
            if (drop_clr_i) drop_m = 0;
            else if (app_tx_valid_i && app_tx_ready_o && !configured_i && drop_m < DROP_MAX) drop_m++;
            if (!configured_i) begin
                rxq.delete();
                txq.delete();
            end
            lp_prev    = loopback_i;
            alive_prev = 1'b1;
        end
    end

    initial begin : host_drv
        bit took;
        usb_out_valid_i = 1'b0;
        usb_out_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            took = usb_out_valid_i && usb_out_ready_o;
            @(posedge clk); #1;
            if (took) begin
                host_src.delete(0);
                usb_out_valid_i = 1'b0;
            end
            if (!usb_out_valid_i && host_src.size() > 0 && (host_burst || $urandom_range(0, 3) != 0)) begin
                usb_out_valid_i = 1'b1;
                usb_out_data_i  = host_src[0];
            end
        end
    end

    initial begin : app_drv
        bit took;
        app_tx_valid_i = 1'b0;
        app_tx_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            took = app_tx_valid_i && app_tx_ready_o;
            @(posedge clk); #1;
            if (took) begin
                app_src.delete(0);
                app_tx_valid_i = 1'b0;
            end
            if (!app_tx_valid_i && app_src.size() > 0 && (app_burst || $urandom_range(0, 3) != 0)) begin
                app_tx_valid_i = 1'b1;
                app_tx_data_i  = app_src[0];
            end
        end
    end

    initial begin : rdy_drv
        app_rx_ready_i = 1'b0;
        usb_in_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            app_rx_ready_i = (rx_rdy_mode == 1) || (rx_rdy_mode == 2 && $urandom_range(0, 1) == 1);
            usb_in_ready_i = (tx_rdy_mode == 1) || (tx_rdy_mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    task automatic push_host_rand(int n);
        for (int i = 0; i < n; i++) host_src.push_back(8'($urandom));
    endtask

    task automatic push_app_rand(int n);
        for (int i = 0; i < n; i++) app_src.push_back(8'($urandom));
    endtask

    task automatic wait_levels(int rxl, int txl, int budget, string name);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (int'(rx_level_o) == rxl && int'(tx_level_o) == txl) break;
        end
        chk({name, "_rx"}, int'(rx_level_o), rxl);
        chk({name, "_tx"}, int'(tx_level_o), txl);
    endtask

    task automatic drain(int budget, string name);
        bit done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (host_src.size() == 0 && app_src.size() == 0 && !usb_out_valid_i && !app_tx_valid_i
                && rxq.size() == 0 && txq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drained"}, done, 1);
    endtask

    task automatic step_to(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        rstn_i = 1'b0; configured_i = 1'b0; loopback_i = 1'b0; drop_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_ready", usb_out_ready_o, 0);
        chk("rst_in_valid", usb_in_valid_o, 0);
        chk("rst_rx_valid", app_rx_valid_o, 0);
        chk("rst_tx_ready", app_tx_ready_o, 0);
        chk("rst_drop", int'(drop_cnt_o), 0);
        step_to(1);
        rstn_i = 1'b1; configured_i = 1'b1;

        // three ordered bytes, level peaks at 3 while the app holds off
        host_burst = 1'b1; rx_rdy_mode = 0;
        host_src.push_back(8'h11); host_src.push_back(8'h22); host_src.push_back(8'h33);
        wait_levels(3, 0, 50, "peak3");
        rx_rdy_mode = 1;
        drain(100, "three");
        chk("three_level", int'(rx_level_o), 0);

        // 20 bytes into a 16-deep RX FIFO with the app stalled
        rx_rdy_mode = 0;
        push_host_rand(20);
        repeat (40) @(negedge clk);
        chk("rxfull_level", int'(rx_level_o), RXD);
        chk("rxfull_ready", usb_out_ready_o, 0);
        chk("rxfull_pending", host_src.size(), 4);
        rx_rdy_mode = 2;
        drain(400, "rxfull");

        // TX full then mixed random traffic
        tx_rdy_mode = 0;
        push_app_rand(20);
        repeat (40) @(negedge clk);
        chk("txfull_level", int'(tx_level_o), TXD);
        chk("txfull_ready", app_tx_ready_o, 0);
        host_burst = 1'b0; app_burst = 1'b0;
        rx_rdy_mode = 2; tx_rdy_mode = 2;
        push_host_rand(40);
        push_app_rand(40);
        drain(2000, "mixed");

        // loopback echo
        step_to(1);
        loopback_i = 1'b1;
        step_to(3);
        host_burst = 1'b1; tx_rdy_mode = 1;
        host_src.push_back(8'hA5); host_src.push_back(8'h5A);
        drain(100, "lp_pair");
        host_burst = 1'b0; tx_rdy_mode = 2;
        push_host_rand(30);
        drain(1000, "lp_rand");
        step_to(1);
        loopback_i = 1'b0;
        step_to(3);

        // unconfigure with TX holding 5 bytes, then count dropped bytes
        app_burst = 1'b1; tx_rdy_mode = 0;
        push_app_rand(5);
        wait_levels(0, 5, 50, "tx5");
        step_to(1);
        configured_i = 1'b0;
        @(negedge clk);
        chk("unconf_in_valid", usb_in_valid_o, 0);
        @(negedge clk);
        chk("unconf_tx_level", int'(tx_level_o), 0);
        push_app_rand(3);
        drain(100, "drop3");
        chk("drop3", int'(drop_cnt_o), 3);
        step_to(1);
        drop_clr_i = 1'b1;
        step_to(1);
        drop_clr_i = 1'b0;
        @(negedge clk);
        chk("drop_clr", int'(drop_cnt_o), 0);

        // saturation, then clear coinciding with an accepted byte
        push_app_rand(20);
        drain(200, "drop20");
        chk("drop_sat", int'(drop_cnt_o), DROP_MAX);
        step_to(1);
        drop_clr_i = 1'b1;
        push_app_rand(1);
        drain(50, "drop_clr_push");
        step_to(1);
        drop_clr_i = 1'b0;
        @(negedge clk);
        chk("drop_clr_push", int'(drop_cnt_o), 0);

        // async reset with levels 7/9
        step_to(1);
        configured_i = 1'b1;
        step_to(2);
        rx_rdy_mode = 0; tx_rdy_mode = 0; host_burst = 1'b1; app_burst = 1'b1;
        push_host_rand(7);
        push_app_rand(9);
        wait_levels(7, 9, 100, "pre_rst");
        @(posedge clk); #3;
        rstn_i = 1'b0;
        #1;
        chk("arst_rx_level", int'(rx_level_o), 0);
        chk("arst_tx_level", int'(tx_level_o), 0);
        chk("arst_rx_valid", app_rx_valid_o, 0);
        chk("arst_in_valid", usb_in_valid_o, 0);
        chk("arst_out_ready", usb_out_ready_o, 0);
        chk("arst_tx_ready", app_tx_ready_o, 0);
        chk("arst_rx_data", app_rx_data_o, 0);
        chk("arst_in_data", usb_in_data_o, 0);
        step_to(2);
        rstn_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_rx", int'(rx_level_o), 0);
        chk("post_rst_tx", int'(tx_level_o), 0);
        rx_rdy_mode = 2; tx_rdy_mode = 2; host_burst = 1'b0; app_burst = 1'b0;
        push_host_rand(20);
        push_app_rand(20);
        drain(1000, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_cdc_stream_bridge.md
Name: usb_cdc_stream_bridge

Overview:
Parametrised buffering bridge between the usb_cdc byte-stream ports (out_* host->device, in_* device->host) and the chip-side application byte interface. It holds independent RX (host->device) and TX (device->host) FIFOs of configurable depth. It adds an internal loopback mode, flushes both FIFOs while the device is unconfigured, and counts application bytes discarded while unconfigured. It sits between u_usb_cdc and the pad-facing ui/uo/uio mapping in the top-level wrapper.

Parameters:
RX_DEPTH, 16, RX FIFO entries; power of two, >=2
TX_DEPTH, 16, TX FIFO entries; power of two, >=2
DROP_UNCONF, 1, 1: accept and discard app TX bytes while unconfigured; 0: hold app_tx_ready_o low while unconfigured
DROP_CNT_W, 16, width of saturating drop counter

Ports:
clk_i  in  1  clock, 48 MHz domain shared with usb_cdc
rstn_i  in  1  asynchronous active-low reset
configured_i  in  1  usb_cdc configured_o
loopback_i  in  1  1 = route RX FIFO output into TX FIFO
usb_out_data_i  in  8  usb_cdc out_data_o
usb_out_valid_i  in  1  usb_cdc out_valid_o
usb_out_ready_o  out  1  to usb_cdc out_ready_i
usb_in_data_o  out  8  to usb_cdc in_data_i
usb_in_valid_o  out  1  to usb_cdc in_valid_i
usb_in_ready_i  in  1  usb_cdc in_ready_o
app_rx_data_o  out  8  received byte
app_rx_valid_o  out  1  received byte valid
app_rx_ready_i  in  1  app accepts received byte
app_tx_data_i  in  8  byte to send
app_tx_valid_i  in  1  byte to send valid
app_tx_ready_o  out  1  bridge accepts byte
rx_level_o  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
tx_level_o  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
drop_cnt_o  out  DROP_CNT_W  bytes discarded while unconfigured, saturating
drop_clr_i  in  1  synchronous clear of drop_cnt_o

Behaviour:
- Reset (rstn_i low, async): FIFOs empty, levels 0, all *_valid_o 0, all *_ready_o 0, drop_cnt_o 0, loopback register 0, data outputs 0.
- Handshake: transfer on any edge where valid & ready both high. Valid, once high, holds with stable data until accepted; ready may toggle freely.
- FIFO write ready = configured & (level < DEPTH); no write-through at full (read and write both requested at full -> read only).
- Read side: valid = configured & (level > 0); data from registered head. A byte written at edge N is presentable after edge N (1-cycle first-word latency).
- Simultaneous read and write at 0 < level < DEPTH: level unchanged. At level 0: write only.
- Pointers wrap modulo DEPTH; level is exact 0..DEPTH.
- Mode register lp <= loopback_i each cycle (1-cycle registration). With lp=1:
  - RX head feeds TX write port.
  - app_rx_valid_o = 0; app_tx_ready_o = 0.
  - Echo transfer occurs when RX nonempty & TX not full.
  - Bytes already queued remain and drain through the new path.
- configured_i low (sampled, same cycle):
  - both FIFOs flushed synchronously (levels 0 next edge), usb_out_ready_o = 0, usb_in_valid_o = 0, app_rx_valid_o = 0.
  - DROP_UNCONF=1 & lp=0: app_tx_ready_o = 1, each accepted byte discarded, drop_cnt_o += 1, saturating at all-ones.
  - DROP_UNCONF=0: app_tx_ready_o = 0.
- drop_clr_i: drop_cnt_o = 0 next edge; clear has priority over a same-cycle increment.
- configured_i rising: FIFOs start empty; normal operation from the next edge.

Test Plan:
- Reset then configured=1, host sends 0x11,0x22,0x33 on usb_out -> app_rx sees the same bytes in order; each app_rx_valid_o rises 1 cycle after its write; rx_level_o peaks at 3, then returns to 0.
- RX_DEPTH=16, app_rx_ready_i=0, host streams 20 bytes -> usb_out_ready_o low after 16 accepted, rx_level_o=16; release ready -> all 20 bytes delivered in order, none lost.
- loopback_i=1, host sends 0xA5,0x5A, usb_in_ready_i=1 -> usb_in_data_o emits 0xA5 then 0x5A; app_rx_valid_o and app_tx_ready_o stay 0.
- TX holds 5 bytes, configured_i drops -> tx_level_o=0 next edge, usb_in_valid_o=0; app pushes 3 bytes -> drop_cnt_o=3; pulse drop_clr_i -> 0.
- DROP_CNT_W=4, 20 bytes pushed while unconfigured -> drop_cnt_o saturates at 15; drop_clr_i coinciding with a push -> 0.
- Assert rstn_i low mid-stream with levels 7/9 -> all outputs return to reset values immediately (async); after release the FIFOs are empty.
